// File: rtl/hash_cash_pkg.sv
// +----------------------------------------------------------------------+
// | hash_cash_pkg : shared op/status/state types for hash_cash_requester |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package hash_cash_pkg;

   typedef enum logic [1:0] {
      OP_READ   = 2'b00,
      OP_WRITE  = 2'b01,
      OP_DELETE = 2'b10,
      OP_RSVD   = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_OK     = 2'b00,
      ST_FULL   = 2'b01,
      ST_BAD_OP = 2'b10
   } status_t;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PROBE   = 3'd1,
      S_CAPTURE = 3'd2,
      S_DEL     = 3'd3,
      S_WR      = 3'd4,
      S_RESP    = 3'd5
   } state_t;

endpackage

`default_nettype wire

// File: rtl/hash_cash_requester_occupancy.sv
// +----------------------------------------------------------------------+
// | occupancy_counter : saturating live-entry counter with wrap flag     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module occupancy_counter #(
   parameter int MAX = 128,
   parameter int CW  = $clog2(MAX + 1)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          inc_i,
   input  logic          dec_i,
   output logic [CW-1:0] count_o,
   output logic          wrap_err_o
);

   localparam logic [CW-1:0] MAX_C = CW'(MAX);

   logic [CW-1:0] count_q, count_d;
   logic          at_max, at_zero;

   assign at_max  = (count_q == MAX_C);
   assign at_zero = (count_q == '0);

   always_comb begin
      count_d    = count_q;
      wrap_err_o = 1'b0;
      if (inc_i && !dec_i) begin
         if (at_max) wrap_err_o = 1'b1;
         else        count_d    = count_q + 1'b1;
      end else if (dec_i && !inc_i) begin
         if (at_zero) wrap_err_o = 1'b1;
         else         count_d    = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) count_q <= '0;
      else          count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/hash_cash_requester.sv
// +----------------------------------------------------------------------+
// | hash_cash_requester : READ/WRITE/DELETE front-end for a hash_cash    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module hash_cash_requester
   import hash_cash_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int KEY_WIDTH  = 32,
   parameter int MEM_SIZE   = 128
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          req_valid_i,
   output logic                          req_ready_o,
   input  logic [1:0]                    req_op_i,
   input  logic [KEY_WIDTH-1:0]          req_key_i,
   input  logic [DATA_WIDTH-1:0]         req_data_i,
   output logic                          rsp_valid_o,
   input  logic                          rsp_ready_i,
   output logic                          rsp_hit_o,
   output logic [DATA_WIDTH-1:0]         rsp_data_o,
   output logic [1:0]                    rsp_status_o,
   output logic [$clog2(MEM_SIZE+1)-1:0] occupancy_o,
   output logic                          proto_err_o,
   output logic                          cache_cs_o,
   output logic                          cache_we_o,
   output logic                          cache_read_en_o,
   output logic                          cache_del_o,
   output logic [KEY_WIDTH-1:0]          cache_key_read_o,
   output logic [KEY_WIDTH-1:0]          cache_key_write_o,
   output logic [DATA_WIDTH-1:0]         cache_data_o,
   input  logic [DATA_WIDTH-1:0]         cache_data_i,
   input  logic                          cache_valid_i,
   input  logic [1:0]                    cache_error_i
);

   localparam int              OCC_W = $clog2(MEM_SIZE + 1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(MEM_SIZE);

   state_t                  state_q, state_d;
   op_t                     op_q, op_d;
   logic [KEY_WIDTH-1:0]    key_q, key_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    hit_q, hit_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   status_t                 status_q, status_d;
   logic                    proto_err_q, proto_err_d;
   logic                    occ_inc, occ_dec, occ_wrap;
   logic [OCC_W-1:0]        occ_count;
   logic                    unused_err_hi;

   assign unused_err_hi = cache_error_i[1];

   occupancy_counter #(.MAX(MEM_SIZE), .CW(OCC_W)) u_occ (
      .clk        (clk),
      .reset_n    (reset_n),
      .inc_i      (occ_inc),
      .dec_i      (occ_dec),
      .count_o    (occ_count),
      .wrap_err_o (occ_wrap)
   );

   always_comb begin
      state_d           = state_q;
      op_d              = op_q;
      key_d             = key_q;
      wdata_d           = wdata_q;
      hit_d             = hit_q;
      rdata_d           = rdata_q;
      status_d          = status_q;
      proto_err_d       = proto_err_q | occ_wrap;
      occ_inc           = 1'b0;
      occ_dec           = 1'b0;
      req_ready_o       = 1'b0;
      rsp_valid_o       = 1'b0;
      cache_cs_o        = 1'b0;
      cache_we_o        = 1'b0;
      cache_read_en_o   = 1'b0;
      cache_del_o       = 1'b0;
      cache_key_read_o  = '0;
      cache_key_write_o = '0;
      cache_data_o      = '0;
      case (state_q)
         S_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               op_d     = op_t'(req_op_i);
               key_d    = req_key_i;
               wdata_d  = req_data_i;
               hit_d    = 1'b0;
               rdata_d  = '0;
               status_d = ST_OK;
               if (op_t'(req_op_i) == OP_RSVD) begin
                  status_d = ST_BAD_OP;
                  state_d  = S_RESP;
               end else begin
                  state_d  = S_PROBE;
               end
            end
         end
         S_PROBE: begin
            cache_cs_o       = 1'b1;
            cache_read_en_o  = 1'b1;
            cache_key_read_o = key_q;
            state_d          = S_CAPTURE;
         end
         S_CAPTURE: begin
            // Cache read data is registered, so it lands one cycle after the probe.
            hit_d   = cache_valid_i;
            rdata_d = (op_q == OP_READ && cache_valid_i) ? cache_data_i : '0;
            case (op_q)
               OP_WRITE: begin
                  if (cache_valid_i) begin
                     state_d = S_DEL;
                  end else if (occ_count == OCC_FULL) begin
                     status_d = ST_FULL;
                     state_d  = S_RESP;
                  end else begin
                     state_d  = S_WR;
                  end
               end
               OP_DELETE: state_d = cache_valid_i ? S_DEL : S_RESP;
               default:   state_d = S_RESP;
            endcase
         end
         S_DEL: begin
            // A replacing write frees the old slot first so the cache never sees a duplicate key.
            cache_cs_o        = 1'b1;
            cache_del_o       = 1'b1;
            cache_key_write_o = key_q;
            occ_dec           = 1'b1;
            state_d           = (op_q == OP_WRITE) ? S_WR : S_RESP;
         end
         S_WR: begin
            cache_cs_o        = 1'b1;
            cache_we_o        = 1'b1;
            cache_key_write_o = key_q;
            cache_data_o      = wdata_q;
            occ_inc           = 1'b1;
            if (cache_error_i[0]) proto_err_d = 1'b1;
            state_d           = S_RESP;
         end
         S_RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         op_q        <= OP_READ;
         key_q       <= '0;
         wdata_q     <= '0;
         hit_q       <= 1'b0;
         rdata_q     <= '0;
         status_q    <= ST_OK;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         key_q       <= key_d;
         wdata_q     <= wdata_d;
         hit_q       <= hit_d;
         rdata_q     <= rdata_d;
         status_q    <= status_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign rsp_hit_o    = hit_q;
   assign rsp_data_o   = rdata_q;
   assign rsp_status_o = status_q;
   assign occupancy_o  = occ_count;
   assign proto_err_o  = proto_err_q;

endmodule

`default_nettype wire

// File: tb/tb_hash_cash_requester.sv
// +----------------------------------------------------------------------+
// | tb_hash_cash_requester : scoreboard bench with a small cache model   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_hash_cash_requester;

   localparam int DW  = 32;
   localparam int KW  = 32;
   localparam int MS  = 4;
   localparam int OCW = $clog2(MS + 1);

   logic           clk = 1'b0;
   logic           reset_n;
   logic           req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i, rsp_hit_o, proto_err_o;
   logic [1:0]     req_op_i, rsp_status_o;
   logic [KW-1:0]  req_key_i, cache_key_read_o, cache_key_write_o;
   logic [DW-1:0]  req_data_i, rsp_data_o, cache_data_o;
   logic [OCW-1:0] occupancy_o;
   logic           cache_cs_o, cache_we_o, cache_read_en_o, cache_del_o;
   logic [DW-1:0]  c_data;
   logic           c_valid;
   logic [1:0]     c_err;

   always #5 clk = ~clk;

   hash_cash_requester #(.DATA_WIDTH(DW), .KEY_WIDTH(KW), .MEM_SIZE(MS)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
      .req_key_i(req_key_i), .req_data_i(req_data_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_hit_o(rsp_hit_o),
      .rsp_data_o(rsp_data_o), .rsp_status_o(rsp_status_o),
      .occupancy_o(occupancy_o), .proto_err_o(proto_err_o),
      .cache_cs_o(cache_cs_o), .cache_we_o(cache_we_o), .cache_read_en_o(cache_read_en_o),
      .cache_del_o(cache_del_o), .cache_key_read_o(cache_key_read_o),
      .cache_key_write_o(cache_key_write_o), .cache_data_o(cache_data_o),
      .cache_data_i(c_data), .cache_valid_i(c_valid), .cache_error_i(c_err)
   );

   // Behavioural CAM cache: registered read, reset by ~reset_n alongside the requester.
   logic [KW-1:0] cm_key [MS];
   logic [DW-1:0] cm_dat [MS];
   logic          cm_vld [MS];

   always_comb begin
      c_err = 2'b00;
      if (cache_cs_o && cache_we_o) begin
         for (int i = 0; i < MS; i++)
            if (cm_vld[i] && cm_key[i] == cache_key_write_o) c_err[0] = 1'b1;
      end
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < MS; i++) cm_vld[i] <= 1'b0;
         c_valid <= 1'b0;
         c_data  <= '0;
      end else if (cache_cs_o) begin
         if (cache_read_en_o) begin
            c_valid <= 1'b0;
            c_data  <= '0;
            for (int i = 0; i < MS; i++)
               if (cm_vld[i] && cm_key[i] == cache_key_read_o) begin
                  c_valid <= 1'b1;
                  c_data  <= cm_dat[i];
               end
         end
         if (cache_del_o) begin
            for (int i = 0; i < MS; i++)
               if (cm_vld[i] && cm_key[i] == cache_key_write_o) cm_vld[i] <= 1'b0;
         end
         if (cache_we_o && !c_err[0]) begin : wr_blk
            int f;
            f = -1;
            for (int i = 0; i < MS; i++) if (!cm_vld[i] && f < 0) f = i;
            if (f >= 0) begin
               cm_vld[f] <= 1'b1;
               cm_key[f] <= cache_key_write_o;
               cm_dat[f] <= cache_data_o;
            end
         end
      end
   end

   int we_cnt = 0;
   int del_cnt = 0;
   always @(posedge clk) begin
      if (reset_n && cache_cs_o && cache_we_o)  we_cnt  <= we_cnt + 1;
      if (reset_n && cache_cs_o && cache_del_o) del_cnt <= del_cnt + 1;
   end

   typedef struct {
      logic          hit;
      logic [DW-1:0] data;
      logic [1:0]    st;
      int            lat;
      int            we_n;
      int            del_n;
   } exp_t;

   exp_t          sb_q [$];
   logic [DW-1:0] ref_mem [logic [KW-1:0]];
   int            checks = 0;
   int            failures = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic txn(input logic [1:0] op, input logic [KW-1:0] key,
                      input logic [DW-1:0] data, input int hold);
      exp_t          e, g;
      int            lat, we0, del0;
      logic          present;
      logic [DW-1:0] h_data;
      logic [1:0]    h_st;
      logic          h_hit;
      present = ref_mem.exists(key) ? 1'b1 : 1'b0;
      e.hit = 1'b0; e.data = '0; e.st = 2'b00; e.lat = 3; e.we_n = 0; e.del_n = 0;
      case (op)
         2'b00: begin
            e.hit = present;
            if (present) e.data = ref_mem[key];
         end
         2'b01: begin
            e.hit = present;
            if (present) begin
               e.lat = 5; e.we_n = 1; e.del_n = 1; ref_mem[key] = data;
            end else if (ref_mem.num() == MS) begin
               e.st = 2'b01;
            end else begin
               e.lat = 4; e.we_n = 1; ref_mem[key] = data;
            end
         end
         2'b10: begin
            e.hit = present;
            if (present) begin
               e.lat = 4; e.del_n = 1; ref_mem.delete(key);
            end
         end
         default: begin
            e.st = 2'b10; e.lat = 1;
         end
      endcase
      sb_q.push_back(e);
      we0 = we_cnt; del0 = del_cnt;
      req_valid_i = 1'b1; req_op_i = op; req_key_i = key; req_data_i = data;
      check("req_ready", 64'(req_ready_o), 64'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0;
      lat = 1;
      while (!rsp_valid_o && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      g = sb_q.pop_front();
      check("latency", 64'(lat), 64'(g.lat));
      check("rsp_hit", 64'(rsp_hit_o), 64'(g.hit));
      check("rsp_data", 64'(rsp_data_o), 64'(g.data));
      check("rsp_status", 64'(rsp_status_o), 64'(g.st));
      h_hit = rsp_hit_o; h_data = rsp_data_o; h_st = rsp_status_o;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", 64'(rsp_valid_o), 64'd1);
         check("hold_ready", 64'(req_ready_o), 64'd0);
         check("hold_stable", {31'd0, rsp_hit_o, rsp_data_o}, {31'd0, h_hit, h_data});
         check("hold_status", 64'(rsp_status_o), 64'(h_st));
      end
      rsp_ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready_i = 1'b0;
      check("rsp_dropped", 64'(rsp_valid_o), 64'd0);
      check("occupancy", 64'(occupancy_o), 64'(ref_mem.num()));
      check("we_pulses", 64'(we_cnt - we0), 64'(g.we_n));
      check("del_pulses", 64'(del_cnt - del0), 64'(g.del_n));
   endtask

   initial begin
      int n;
      reset_n = 1'b0; req_valid_i = 1'b0; req_op_i = 2'b00; req_key_i = '0;
      req_data_i = '0; rsp_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", 64'(req_ready_o), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("rst_rsp", {29'd0, rsp_hit_o, rsp_status_o, rsp_data_o}, 64'd0);
      check("rst_occ_err", 64'({occupancy_o, proto_err_o}), 64'd0);
      check("rst_cache_ctl", 64'({cache_cs_o, cache_we_o, cache_read_en_o, cache_del_o}), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      txn(2'b01, 32'h10, 32'hAA, 0);
      txn(2'b00, 32'h10, 32'h0, 0);
      txn(2'b00, 32'h99, 32'h0, 0);
      txn(2'b01, 32'h10, 32'hBB, 0);
      txn(2'b00, 32'h10, 32'h0, 0);
      check("proto_err", 64'(proto_err_o), 64'd0);
      txn(2'b10, 32'h77, 32'h0, 0);
      txn(2'b01, 32'h20, 32'h1234, 0);
      txn(2'b01, 32'h30, 32'h5678, 0);
      txn(2'b01, 32'h40, 32'h9ABC, 0);
      txn(2'b01, 32'h50, 32'hDEAD, 0);
      txn(2'b10, 32'h20, 32'h0, 0);
      txn(2'b01, 32'h50, 32'hDEAD, 0);
      txn(2'b00, 32'h50, 32'h0, 0);
      txn(2'b11, 32'h30, 32'h0, 5);
      check("proto_err_end", 64'(proto_err_o), 64'd0);

      // Replace an existing key and pull reset while the delete pulse is on the pins.
      req_valid_i = 1'b1; req_op_i = 2'b01; req_key_i = 32'h30; req_data_i = 32'h1;
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0;
      n = 0;
      while (!cache_del_o && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("saw_del_state", 64'(cache_del_o), 64'd1);
      #1 reset_n = 1'b0;
      #1;
      check("async_rst_ctl", 64'({cache_cs_o, cache_we_o, cache_read_en_o, cache_del_o}), 64'd0);
      check("async_rst_rdy", 64'({req_ready_o, rsp_valid_o}), 64'b10);
      check("async_rst_occ", 64'(occupancy_o), 64'd0);
      check("async_rst_rsp", {29'd0, rsp_hit_o, rsp_status_o, rsp_data_o}, 64'd0);
      ref_mem.delete();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      txn(2'b00, 32'h30, 32'h0, 0);
      txn(2'b00, 32'h40, 32'h0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
